// File: rtl/cs_reg_bank_if.sv
// Register access port between the scan-chain access controller and the bank.
interface cs_reg_bank_if #(
   parameter int unsigned DW = 17,
   parameter int unsigned AW = 3
);
   logic          reg_wen;
   logic          reg_ren;
   logic [AW-1:0] reg_addr;
   logic [DW-1:0] reg_wdata;
   logic [DW-1:0] reg_rdata;
   logic          reg_ready;
   logic          reg_err;

   modport master (
      output reg_wen, reg_ren, reg_addr, reg_wdata,
      input  reg_rdata, reg_ready, reg_err
   );

   modport slave (
      input  reg_wen, reg_ren, reg_addr, reg_wdata,
      output reg_rdata, reg_ready, reg_err
   );
endinterface

// File: rtl/cs_reg_bank.sv
// Control/status register bank: N_CR r/w control registers, N_SR sampled
// status registers, a write-1-to-clear sticky event register, an interrupt
// enable register and a registered interrupt output.
module cs_reg_bank #(
   parameter int unsigned         DW     = 17,
   parameter int unsigned         N_CR   = 4,
   parameter int unsigned         N_SR   = 2,
   parameter int unsigned         AW     = 3,
   parameter logic [DW*N_CR-1:0]  CR_RST = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   cs_reg_bank_if.slave       reg_bus,
   output logic [DW*N_CR-1:0] cr,
   input  logic [DW*N_SR-1:0] sr_in,
   input  logic [DW-1:0]      evt_in,
   output logic               irq
);

   localparam int unsigned E_ADDR   = N_CR + N_SR;
   localparam int unsigned IEN_ADDR = N_CR + N_SR + 1;

   // Every register plus EVT and IEN must fit in the address space.
   if (N_CR + N_SR + 2 > 2**AW) begin : g_bad_cfg
      $error("cs_reg_bank: N_CR+N_SR+2 exceeds 2**AW");
   end

   logic [N_CR-1:0][DW-1:0] cr_q, cr_d;
   logic [N_SR-1:0][DW-1:0] sr_q;
   logic [DW-1:0]           evt_q, evt_d;
   logic [DW-1:0]           ien_q, ien_d;
   logic [DW-1:0]           rdata_q, rdata_d;
   logic                    ready_q, ready_d;
   logic                    err_q, err_d;
   logic                    irq_q, irq_d;
   logic [DW-1:0]           evt_clr;
   logic                    addr_hit;

   // Address decode, write effects, read mux and sticky/irq next state.
   always_comb begin
      cr_d     = cr_q;
      ien_d    = ien_q;
      rdata_d  = '0;
      err_d    = 1'b0;
      ready_d  = reg_bus.reg_wen | reg_bus.reg_ren;
      evt_clr  = '0;
      addr_hit = 1'b0;

      for (int i = 0; i < int'(N_CR); i++) begin
         if (reg_bus.reg_addr == AW'(i)) begin
            addr_hit = 1'b1;
            if (reg_bus.reg_wen)      cr_d[i] = reg_bus.reg_wdata;
            else if (reg_bus.reg_ren) rdata_d = cr_q[i];
         end
      end

      for (int j = 0; j < int'(N_SR); j++) begin
         if (reg_bus.reg_addr == AW'(N_CR + j)) begin
            addr_hit = 1'b1;
            if (reg_bus.reg_wen)      err_d   = 1'b1;
            else if (reg_bus.reg_ren) rdata_d = sr_q[j];
         end
      end

      if (reg_bus.reg_addr == AW'(E_ADDR)) begin
         addr_hit = 1'b1;
         if (reg_bus.reg_wen)      evt_clr = reg_bus.reg_wdata;
         else if (reg_bus.reg_ren) rdata_d = evt_q;
      end

      if (reg_bus.reg_addr == AW'(IEN_ADDR)) begin
         addr_hit = 1'b1;
         if (reg_bus.reg_wen)      ien_d   = reg_bus.reg_wdata;
         else if (reg_bus.reg_ren) rdata_d = ien_q;
      end

      if (!addr_hit && (reg_bus.reg_wen || reg_bus.reg_ren)) begin
         err_d   = 1'b1;
         rdata_d = '0;
      end

      // A new event on a bit being cleared wins: the OR comes last.
      evt_d = (evt_q & ~evt_clr) | evt_in;
      irq_d = |(evt_d & ien_d);
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cr_q    <= CR_RST;
         sr_q    <= '0;
         evt_q   <= '0;
         ien_q   <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         cr_q    <= cr_d;
         sr_q    <= sr_in;
         evt_q   <= evt_d;
         ien_q   <= ien_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         irq_q   <= irq_d;
      end
   end

   assign reg_bus.reg_rdata = rdata_q;
   assign reg_bus.reg_ready = ready_q;
   assign reg_bus.reg_err   = err_q;
   assign cr                = cr_q;
   assign irq               = irq_q;

endmodule

// File: tb/tb_cs_reg_bank.sv
// Bench for cs_reg_bank: directed vector table, reset/config corner cases,
// then random traffic checked against a behavioural model.
module tb_cs_reg_bank;
   localparam int DW   = 17;
   localparam int N_CR = 4;
   localparam int N_SR = 2;
   localparam int AW   = 3;
   localparam int E    = N_CR + N_SR;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Main instance (N_SR=2) and a second one with N_SR=1 to reach an unmapped address.
   cs_reg_bank_if #(.DW(DW), .AW(AW)) u_bus ();
   cs_reg_bank_if #(.DW(DW), .AW(AW)) u_bus1 ();

   logic [DW*N_CR-1:0] cr;
   logic [DW*N_SR-1:0] sr_in;
   logic [DW-1:0]      evt_in;
   logic               irq;

   logic [DW*N_CR-1:0] cr1;
   logic [DW-1:0]      sr1;
   logic [DW-1:0]      evt1;
   logic               irq1;

   cs_reg_bank #(.DW(DW), .N_CR(N_CR), .N_SR(N_SR), .AW(AW), .CR_RST('0)) dut (
      .clk(clk), .rst_n(rst_n), .reg_bus(u_bus.slave),
      .cr(cr), .sr_in(sr_in), .evt_in(evt_in), .irq(irq)
   );

   cs_reg_bank #(.DW(DW), .N_CR(N_CR), .N_SR(1), .AW(AW), .CR_RST('0)) dut1 (
      .clk(clk), .rst_n(rst_n), .reg_bus(u_bus1.slave),
      .cr(cr1), .sr_in(sr1), .evt_in(evt1), .irq(irq1)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model of the main instance.
   logic [DW-1:0] m_cr [N_CR];
   logic [DW-1:0] m_sr [N_SR];
   logic [DW-1:0] m_evt, m_ien, e_rd;
   logic          e_rdy, e_err, e_irq;

   task automatic model_reset();
      for (int i = 0; i < N_CR; i++) m_cr[i] = '0;
      for (int i = 0; i < N_SR; i++) m_sr[i] = '0;
      m_evt = '0; m_ien = '0; e_rd = '0;
      e_rdy = 1'b0; e_err = 1'b0; e_irq = 1'b0;
   endtask

   function automatic logic [DW*N_CR-1:0] m_cr_pack();
      return {m_cr[3], m_cr[2], m_cr[1], m_cr[0]};
   endfunction

   task automatic model_step(input logic wen, input logic ren, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic [DW*N_SR-1:0] sr,
                             input logic [DW-1:0] ev);
      int a;
      logic [DW-1:0] clr;
      a = int'(addr);
      clr = '0;
      e_rdy = wen | ren;
      e_rd  = '0;
      e_err = 1'b0;
      if (wen) begin
         if (a < N_CR)       m_cr[a] = wd;
         else if (a < E)     e_err = 1'b1;
         else if (a == E)    clr = wd;
         else if (a == E+1)  m_ien = wd;
         else                e_err = 1'b1;
      end else if (ren) begin
         if (a < N_CR)       e_rd = m_cr[a];
         else if (a < E)     e_rd = m_sr[a-N_CR];
         else if (a == E)    e_rd = m_evt;
         else if (a == E+1)  e_rd = m_ien;
         else                e_err = 1'b1;
      end
      m_evt = (m_evt & ~clr) | ev;
      e_irq = (m_evt & m_ien) != '0;
      m_sr[0] = sr[16:0];
      m_sr[1] = sr[33:17];
   endtask

   // Apply one request cycle to the main instance and advance the model.
   task automatic cycle(input logic wen, input logic ren, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW*N_SR-1:0] sr,
                        input logic [DW-1:0] ev);
      u_bus.reg_wen   = wen;
      u_bus.reg_ren   = ren;
      u_bus.reg_addr  = addr;
      u_bus.reg_wdata = wd;
      sr_in  = sr;
      evt_in = ev;
      model_step(wen, ren, addr, wd, sr, ev);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, " rdata"}, 128'(u_bus.reg_rdata), 128'(e_rd));
      chk({tag, " ready"}, 128'(u_bus.reg_ready), 128'(e_rdy));
      chk({tag, " err"},   128'(u_bus.reg_err),   128'(e_err));
      chk({tag, " irq"},   128'(irq),             128'(e_irq));
      chk({tag, " cr"},    128'(cr),              128'(m_cr_pack()));
   endtask

   typedef struct {
      logic                wen;
      logic                ren;
      logic [AW-1:0]       addr;
      logic [DW-1:0]       wdata;
      logic [DW*N_SR-1:0]  sr;
      logic [DW-1:0]       evt;
      logic [DW-1:0]       x_rd;
      logic                x_rdy;
      logic                x_err;
      logic                x_irq;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //             wen   ren   addr  wdata      sr        evt       rd         rdy   err   irq
      tbl[0]  = '{1'b1, 1'b0, 3'd2, 17'h1ABCD, 34'h00, 17'h00, 17'h00000, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 3'd2, 17'h00000, 34'h00, 17'h00, 17'h1ABCD, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 3'd2, 17'h00000, 34'h00, 17'h00, 17'h00000, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 3'd0, 17'h00000, 34'h55, 17'h00, 17'h00000, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 3'd4, 17'h00000, 34'h55, 17'h00, 17'h00055, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 3'd4, 17'h1FFFF, 34'h77, 17'h00, 17'h00000, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 3'd4, 17'h00000, 34'h77, 17'h00, 17'h00077, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 3'd0, 17'h00003, 34'h77, 17'h00, 17'h00000, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 3'd0, 17'h00000, 34'h77, 17'h00, 17'h00003, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 3'd0, 17'h00000, 34'h77, 17'h10, 17'h00000, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 3'd6, 17'h00000, 34'h77, 17'h00, 17'h00010, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 3'd7, 17'h00010, 34'h77, 17'h00, 17'h00000, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 3'd6, 17'h00010, 34'h77, 17'h10, 17'h00000, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 3'd6, 17'h00000, 34'h77, 17'h00, 17'h00010, 1'b1, 1'b0, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 3'd6, 17'h00010, 34'h77, 17'h00, 17'h00000, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 3'd6, 17'h00000, 34'h77, 17'h00, 17'h00000, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 3'd7, 17'h00000, 34'h77, 17'h00, 17'h00010, 1'b1, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 3'd3, 17'h00000, 34'h77, 17'h00, 17'h00000, 1'b1, 1'b0, 1'b0};

      // Initial reset, both instances idle.
      rst_n = 1'b0;
      u_bus.reg_wen = 1'b0;  u_bus.reg_ren = 1'b0;  u_bus.reg_addr = '0;  u_bus.reg_wdata = '0;
      u_bus1.reg_wen = 1'b0; u_bus1.reg_ren = 1'b0; u_bus1.reg_addr = '0; u_bus1.reg_wdata = '0;
      sr_in = '0; evt_in = '0; sr1 = '0; evt1 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset");
      rst_n = 1'b1;

      // Directed vector table.
      for (int k = 0; k < NV; k++) begin
         cycle(tbl[k].wen, tbl[k].ren, tbl[k].addr, tbl[k].wdata, tbl[k].sr, tbl[k].evt);
         chk($sformatf("tbl%0d rdata", k), 128'(u_bus.reg_rdata), 128'(tbl[k].x_rd));
         chk($sformatf("tbl%0d ready", k), 128'(u_bus.reg_ready), 128'(tbl[k].x_rdy));
         chk($sformatf("tbl%0d err", k),   128'(u_bus.reg_err),   128'(tbl[k].x_err));
         chk($sformatf("tbl%0d irq", k),   128'(irq),             128'(tbl[k].x_irq));
         chk($sformatf("tbl%0d cr", k),    128'(cr),              128'(m_cr_pack()));
      end
      chk("cr2 after table", 128'(cr[2*DW +: DW]), 128'(17'h1ABCD));

      // Reset arriving together with a read request drops the access.
      cycle(1'b1, 1'b0, 3'd0, 17'h1FFFF, 34'h77, 17'h10);
      chk("pre-reset cr0", 128'(cr[DW-1:0]), 128'(17'h1FFFF));
      chk("pre-reset irq", 128'(irq), 128'(1'b1));
      rst_n = 1'b0;
      u_bus.reg_wen = 1'b0; u_bus.reg_ren = 1'b1; u_bus.reg_addr = 3'd0;
      evt_in = '0;
      @(posedge clk);
      #1;
      model_reset();
      m_sr[0] = 17'h77;
      chk("rst ready", 128'(u_bus.reg_ready), 128'(1'b0));
      chk("rst rdata", 128'(u_bus.reg_rdata), 128'(17'h0));
      chk("rst cr",    128'(cr),              128'(0));
      chk("rst irq",   128'(irq),             128'(1'b0));
      rst_n = 1'b1;
      model_reset();
      // sr_q was cleared by reset; next cycle it resamples sr_in.
      cycle(1'b0, 1'b0, 3'd0, 17'h0, 34'h77, 17'h0);
      chk_all("post-reset");

      // N_SR=1 instance: IEN at 6, address 7 unmapped.
      u_bus1.reg_wen = 1'b1; u_bus1.reg_ren = 1'b0; u_bus1.reg_addr = 3'd6; u_bus1.reg_wdata = 17'h10;
      cycle(1'b0, 1'b0, 3'd0, 17'h0, 34'h77, 17'h0);
      chk("nsr1 ien wr err", 128'(u_bus1.reg_err), 128'(1'b0));
      u_bus1.reg_wen = 1'b0; u_bus1.reg_ren = 1'b1; u_bus1.reg_addr = 3'd7; u_bus1.reg_wdata = '0;
      cycle(1'b0, 1'b0, 3'd0, 17'h0, 34'h77, 17'h0);
      chk("nsr1 rd7 ready", 128'(u_bus1.reg_ready), 128'(1'b1));
      chk("nsr1 rd7 rdata", 128'(u_bus1.reg_rdata), 128'(17'h0));
      chk("nsr1 rd7 err",   128'(u_bus1.reg_err),   128'(1'b1));
      u_bus1.reg_addr = 3'd6;
      cycle(1'b0, 1'b0, 3'd0, 17'h0, 34'h77, 17'h0);
      chk("nsr1 rd6 rdata", 128'(u_bus1.reg_rdata), 128'(17'h10));
      chk("nsr1 rd6 err",   128'(u_bus1.reg_err),   128'(1'b0));
      u_bus1.reg_wen = 1'b1; u_bus1.reg_ren = 1'b0; u_bus1.reg_addr = 3'd7; u_bus1.reg_wdata = 17'h5;
      cycle(1'b0, 1'b0, 3'd0, 17'h0, 34'h77, 17'h0);
      chk("nsr1 wr7 err",   128'(u_bus1.reg_err),   128'(1'b1));
      u_bus1.reg_wen = 1'b0;
      cycle(1'b0, 1'b0, 3'd0, 17'h0, 34'h77, 17'h0);
      chk("nsr1 idle ready", 128'(u_bus1.reg_ready), 128'(1'b0));

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic          w, r;
         logic [AW-1:0] a;
         logic [DW-1:0] wd, ev;
         logic [DW*N_SR-1:0] sr;
         w  = ($urandom_range(0, 2) == 0);
         r  = ($urandom_range(0, 2) == 0);
         a  = AW'($urandom_range(0, 7));
         wd = DW'($urandom);
         if ($urandom_range(0, 3) == 0) wd = '1;
         sr = (DW*N_SR)'({$urandom, $urandom});
         ev = ($urandom_range(0, 4) == 0) ? DW'(17'h1 << $urandom_range(0, 16)) : '0;
         cycle(w, r, a, wd, sr, ev);
         chk_all($sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cs_reg_bank.md
Name: cs_reg_bank

Overview:
- Parametrised control/status register bank; next generation of the scan-chain control/status register pair.
- Provides N_CR addressable read/write control registers and N_SR read-only status registers sampled from the core.
- Adds a sticky event register (write-1-to-clear), an interrupt-enable register, an error flag and an interrupt output.
- Sits between the scan-chain register access port and core logic. The access port is a single-cycle request with a one-cycle-later ready pulse.

Parameters:
- DW, 17: data width of every register.
- N_CR, 4: number of control registers.
- N_SR, 2: number of status registers.
- AW, 3: address width. Elaboration must fail unless N_CR+N_SR+2 <= 2**AW.
- CR_RST, 0: reset value of all control registers, DW*N_CR bits, CR i in bits [i*DW +: DW].

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- reg_wen  in  1  write request, one cycle.
- reg_ren  in  1  read request, one cycle.
- reg_addr  in  AW  register address.
- reg_wdata  in  DW  write data.
- reg_rdata  out  DW  read data, valid while reg_ready=1.
- reg_ready  out  1  access-complete pulse.
- reg_err  out  1  access error, qualifies reg_ready.
- cr  out  DW*N_CR  control register contents to core.
- sr_in  in  DW*N_SR  core status inputs.
- evt_in  in  DW  core event pulses, one bit per event.
- irq  out  1  interrupt.

Behaviour:
- Reset, while rst_n=0 at a clk edge:
  - cr=CR_RST; sampled status, evt_sticky and irq_en=0.
  - reg_rdata=0, reg_ready=0, reg_err=0, irq=0.
  - An access in progress when reset asserts is dropped: no ready pulse.
- Address map, with E=N_CR+N_SR:
  - CR i at address i.
  - SR j at address N_CR+j.
  - EVT at address E.
  - IEN at address E+1.
  - Addresses >= E+2 are unmapped.
- Status sampling: sr_q <= sr_in every cycle, except during reset. Reads return sr_q, which is one cycle old relative to sr_in.
- Priority: if reg_wen and reg_ren are both 1, the write is performed and the read is ignored.
- Write behaviour:
  - CR: cr[i] <= reg_wdata.
  - IEN: irq_en <= reg_wdata.
  - EVT: write-1-to-clear of evt_sticky bits.
  - SR or unmapped address: no state change, reg_err=1.
  - Every write gives reg_ready=1 in the next cycle, with reg_rdata=0.
- Read behaviour:
  - Next cycle: reg_ready=1 and reg_rdata = value of the addressed register at the request edge; reg_err=0.
  - Unmapped address: reg_rdata=0, reg_err=1.
- Idle cycles (no request): reg_ready, reg_err and reg_rdata are all 0 in the next cycle. Back-to-back requests produce back-to-back ready pulses; the block never stalls.
- Sticky events: evt_sticky <= (evt_sticky & ~clr) | evt_in.
  - clr = reg_wdata when writing EVT, else 0.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Interrupt: irq <= |(evt_sticky_next & irq_en_next). It is registered, so it rises one cycle after the causing event or enable write.
- CR updates appear on cr the cycle after the write edge. CR and IEN are unaffected by reads.
- Width rule: all data paths are exactly DW bits; no truncation or extension.

Test Plan (DW=17, N_CR=4, N_SR=2, AW=3, CR_RST=0):
- Write 0x1ABCD to addr 2, then read addr 2:
  - Write: ready pulse, rdata=0, err=0.
  - Read: next cycle ready=1, rdata=0x1ABCD, err=0.
  - cr[2*17 +: 17]=0x1ABCD; the other CRs stay 0.
- Hold sr_in[16:0]=0x00055, then read addr 4 -> rdata=0x00055. Write addr 4 -> err=1, and sr_q is still driven from sr_in.
- Drive reg_wen=1 and reg_ren=1 together, addr 0, wdata 0x00003 -> cr[0]=0x00003, rdata=0 (write wins). A following read of addr 0 returns 0x00003.
- Events and interrupt:
  - Pulse evt_in=0x00010, then read EVT (addr 6) -> 0x00010.
  - Write IEN=0x00010 -> irq=1 one cycle later.
  - Write EVT=0x00010 in the same cycle as evt_in=0x00010 -> bit stays 1.
  - Repeat the clear with no event -> bit=0 and irq=0 next cycle.
- Read addr 7 with IEN=0x00010 -> 0x00010. There is no unmapped address in this config; rerun with N_SR=1 and read addr 7 -> rdata=0, err=1.
- Write cr[0]=0x1FFFF, then assert rst_n=0 for 1 cycle concurrently with a read request:
  - No ready pulse.
  - Next cycle cr=0, reg_rdata=0, irq=0.
